// File: rtl/arf192b080e1r1w0cbbehbaa4acw_port_sched.sv
// Write-port round-robin arbiter, read issue and clock-gate enables for the 192x80 1R1W array.
// Optional: ARF192B080_PORT_SCHED_BYPASS_EN forwards same-cycle write data to a hazard read.
module arf192b080e1r1w0cbbehbaa4acw_port_sched #(
    parameter int NREQ  = 4,
    parameter int AW    = 8,
    parameter int DW    = 80,
    parameter int DEPTH = 192,
    parameter int HOLD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wr_req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      wr_gnt,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    output logic                 rd_gnt,
    output logic                 arr_wen,
    output logic [AW-1:0]        arr_waddr,
    output logic [DW-1:0]        arr_wdata,
    output logic                 arr_ren,
    output logic [AW-1:0]        arr_raddr,
    input  logic [DW-1:0]        arr_rdata,
    output logic                 rd_vld,
    output logic [DW-1:0]        rd_data,
    output logic                 wclk_en,
    output logic                 rclk_en,
    output logic                 addr_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] NR = (PW+1)'(NREQ);
    localparam logic [AW:0] DEP = (AW+1)'(DEPTH);
    localparam logic [2:0] HLD = 3'(HOLD);

`ifdef ARF192B080_PORT_SCHED_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic [AW-1:0] wa [NREQ];
    logic [DW-1:0] wd [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wa[i] = wr_addr[i*AW +: AW];
        assign wd[i] = wr_data[i*DW +: DW];
    end

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] nptr;
    logic [PW:0]   cand;
    logic          any_gnt;

    // Rotating search starting at ptr; first requester found wins.
    always_comb begin
        any_gnt = 1'b0;
        gidx    = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= NR) cand = cand - NR;
            if (!any_gnt && wr_req[cand[PW-1:0]]) begin
                any_gnt = 1'b1;
                gidx    = cand[PW-1:0];
            end
        end
        if (rst) any_gnt = 1'b0;
    end

    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;
    logic          w_ok;
    logic          r_ok;
    logic          hazard;

    assign nptr   = (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
    assign wr_gnt = any_gnt ? (NREQ'(1) << gidx) : '0;
    assign gaddr  = wa[gidx];
    assign gdata  = wd[gidx];
    assign w_ok   = any_gnt && ({1'b0, gaddr} < DEP);
    assign r_ok   = {1'b0, rd_addr} < DEP;
    assign hazard = rd_req && w_ok && (rd_addr == gaddr);

`ifdef ARF192B080_PORT_SCHED_BYPASS_EN
    assign rd_gnt = rd_req && !rst;
`else
    assign rd_gnt = rd_req && !hazard && !rst;
`endif

    logic          s1_vld, s1_ok, s1_byp;
    logic          s2_vld, s2_ok, s2_byp;
    logic [DW-1:0] byp_q;
    logic [2:0]    hcnt_w, hcnt_r;
    logic [2:0]    hw_nxt, hr_nxt;
    logic          r_issue;

    assign r_issue = rd_gnt && r_ok;
    assign hw_nxt  = arr_wen ? HLD : ((hcnt_w != 3'd0) ? hcnt_w - 3'd1 : 3'd0);
    assign hr_nxt  = arr_ren ? HLD : ((hcnt_r != 3'd0) ? hcnt_r - 3'd1 : 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            arr_wen   <= 1'b0;
            arr_waddr <= '0;
            arr_wdata <= '0;
            arr_ren   <= 1'b0;
            arr_raddr <= '0;
            s1_vld    <= 1'b0;
            s1_ok     <= 1'b0;
            s1_byp    <= 1'b0;
            s2_vld    <= 1'b0;
            s2_ok     <= 1'b0;
            s2_byp    <= 1'b0;
            byp_q     <= '0;
            rd_vld    <= 1'b0;
            rd_data   <= '0;
            hcnt_w    <= '0;
            hcnt_r    <= '0;
            wclk_en   <= 1'b0;
            rclk_en   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            if (any_gnt) ptr <= nptr;
            arr_wen <= w_ok;
            if (w_ok) begin
                arr_waddr <= gaddr;
                arr_wdata <= gdata;
            end
            arr_ren <= r_issue;
            if (r_issue) arr_raddr <= rd_addr;
            s1_vld <= rd_gnt;
            s1_ok  <= r_ok;
            s1_byp <= BYP && hazard && rd_gnt;
            s2_vld <= s1_vld;
            s2_ok  <= s1_ok;
            s2_byp <= s1_byp;
            // arr_wdata of a hazard write is live exactly while its read is in s1.
            if (s1_byp) byp_q <= arr_wdata;
            rd_vld <= s2_vld;
            if (s2_vld) begin
                rd_data <= !s2_ok ? '0 : (s2_byp ? byp_q : arr_rdata);
            end
            hcnt_w  <= hw_nxt;
            hcnt_r  <= hr_nxt;
            wclk_en <= w_ok || (hw_nxt != 3'd0);
            rclk_en <= r_issue || (hr_nxt != 3'd0);
            if ((any_gnt && !w_ok) || (rd_gnt && !r_ok)) addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arf192b080e1r1w0cbbehbaa4acw_port_sched.sv
// Randomized and directed bench for the register-file port scheduler.
module tb_arf192b080e1r1w0cbbehbaa4acw_port_sched;

    localparam int NREQ  = 4;
    localparam int AW    = 8;
    localparam int DW    = 80;
    localparam int DEPTH = 192;
    localparam int HOLD  = 2;
    localparam int N     = 4096;

`ifdef ARF192B080_PORT_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst = 1'b1;
    logic [NREQ-1:0]     wr_req = '0;
    logic [NREQ*AW-1:0]  wr_addr = '0;
    logic [NREQ*DW-1:0]  wr_data = '0;
    logic [NREQ-1:0]     wr_gnt;
    logic                rd_req = 1'b0;
    logic [AW-1:0]       rd_addr = '0;
    logic                rd_gnt;
    logic                arr_wen;
    logic [AW-1:0]       arr_waddr;
    logic [DW-1:0]       arr_wdata;
    logic                arr_ren;
    logic [AW-1:0]       arr_raddr;
    logic [DW-1:0]       arr_rdata = '0;
    logic                rd_vld;
    logic [DW-1:0]       rd_data;
    logic                wclk_en;
    logic                rclk_en;
    logic                addr_err;

    arf192b080e1r1w0cbbehbaa4acw_port_sched #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH), .HOLD(HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .arr_wen(arr_wen), .arr_waddr(arr_waddr), .arr_wdata(arr_wdata),
        .arr_ren(arr_ren), .arr_raddr(arr_raddr), .arr_rdata(arr_rdata),
        .rd_vld(rd_vld), .rd_data(rd_data),
        .wclk_en(wclk_en), .rclk_en(rclk_en), .addr_err(addr_err)
    );

    // Array stand-in: one-cycle read latency, read-before-write on conflict.
    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (arr_ren) arr_rdata <= mem[arr_raddr];
        if (arr_wen) mem[arr_waddr] <= arr_wdata;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: contents as seen by a read granted now, plus per-cycle expectations.
    logic [DW-1:0] refmem [256] = '{default: '0};
    bit            e_wen [N];
    logic [AW-1:0] e_waddr [N];
    logic [DW-1:0] e_wdata [N];
    bit            e_ren [N];
    logic [AW-1:0] e_raddr [N];
    bit            e_vld [N];
    logic [DW-1:0] e_rdata [N];
    int            mptr;
    bit            err_m;
    int            last_w;
    int            last_r;
    int            last_gnt;
    bit            last_rg;
    logic [NREQ-1:0] obs_gnt;
    logic          obs_rgnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            e_wen[i] = 1'b0;
            e_ren[i] = 1'b0;
            e_vld[i] = 1'b0;
        end
        mptr   = 0;
        err_m  = 1'b0;
        last_w = -100;
        last_r = -100;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        wr_req[i] = 1'b1;
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, 16'($urandom)};
    endfunction

    // One clock: check grants against the rules, schedule effects, check outputs.
    task automatic tick();
        int mg;
        int idx;
        logic [NREQ-1:0] exp_g;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        bit wl, rl, haz, rg;
        #1;
        mg = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (mg < 0 && wr_req[idx]) mg = idx;
        end
        exp_g = '0;
        ga = '0;
        gd = '0;
        wl = 1'b0;
        if (mg >= 0) begin
            exp_g[mg] = 1'b1;
            ga = wr_addr[mg*AW +: AW];
            gd = wr_data[mg*DW +: DW];
            wl = (int'(ga) < DEPTH);
        end
        rl  = (int'(rd_addr) < DEPTH);
        haz = rd_req && wl && (rd_addr == ga);
        rg  = rd_req && (BYP || !haz);
        obs_gnt  = wr_gnt;
        obs_rgnt = rd_gnt;
        checks++;
        if (wr_gnt !== exp_g) begin
            errors++;
            $display("FAIL wr_gnt cyc=%0d got=%b exp=%b", cyc, wr_gnt, exp_g);
        end
        checks++;
        if (rd_gnt !== rg) begin
            errors++;
            $display("FAIL rd_gnt cyc=%0d got=%b exp=%b", cyc, rd_gnt, rg);
        end
        if (mg >= 0) begin
            mptr = (mg + 1) % NREQ;
            if (wl) begin
                e_wen[cyc+1]   = 1'b1;
                e_waddr[cyc+1] = ga;
                e_wdata[cyc+1] = gd;
                refmem[ga]     = gd;
            end else begin
                err_m = 1'b1;
            end
        end
        if (rg) begin
            e_vld[cyc+3]   = 1'b1;
            e_rdata[cyc+3] = rl ? refmem[rd_addr] : '0;
            if (rl) begin
                e_ren[cyc+1]   = 1'b1;
                e_raddr[cyc+1] = rd_addr;
            end else begin
                err_m = 1'b1;
            end
        end
        last_gnt = mg;
        last_rg  = rg;
        @(posedge clk);
        #1;
        cyc++;
        if (e_wen[cyc]) last_w = cyc;
        if (e_ren[cyc]) last_r = cyc;
        checks++;
        if (arr_wen !== e_wen[cyc]) begin
            errors++;
            $display("FAIL arr_wen cyc=%0d got=%b exp=%b", cyc, arr_wen, e_wen[cyc]);
        end
        if (e_wen[cyc]) begin
            checks++;
            if (arr_waddr !== e_waddr[cyc] || arr_wdata !== e_wdata[cyc]) begin
                errors++;
                $display("FAIL arr_wcmd cyc=%0d got=%h/%h exp=%h/%h", cyc,
                         arr_waddr, arr_wdata, e_waddr[cyc], e_wdata[cyc]);
            end
        end
        checks++;
        if (arr_ren !== e_ren[cyc]) begin
            errors++;
            $display("FAIL arr_ren cyc=%0d got=%b exp=%b", cyc, arr_ren, e_ren[cyc]);
        end
        if (e_ren[cyc]) begin
            checks++;
            if (arr_raddr !== e_raddr[cyc]) begin
                errors++;
                $display("FAIL arr_raddr cyc=%0d got=%h exp=%h", cyc,
                         arr_raddr, e_raddr[cyc]);
            end
        end
        checks++;
        if (rd_vld !== e_vld[cyc]) begin
            errors++;
            $display("FAIL rd_vld cyc=%0d got=%b exp=%b", cyc, rd_vld, e_vld[cyc]);
        end
        if (e_vld[cyc]) begin
            checks++;
            if (rd_data !== e_rdata[cyc]) begin
                errors++;
                $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc,
                         rd_data, e_rdata[cyc]);
            end
        end
        checks++;
        if (wclk_en !== (cyc - last_w <= HOLD)) begin
            errors++;
            $display("FAIL wclk_en cyc=%0d got=%b exp=%b", cyc, wclk_en,
                     (cyc - last_w <= HOLD));
        end
        checks++;
        if (rclk_en !== (cyc - last_r <= HOLD)) begin
            errors++;
            $display("FAIL rclk_en cyc=%0d got=%b exp=%b", cyc, rclk_en,
                     (cyc - last_r <= HOLD));
        end
        checks++;
        if (addr_err !== err_m) begin
            errors++;
            $display("FAIL addr_err cyc=%0d got=%b exp=%b", cyc, addr_err, err_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_req = 4'b1111;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wr_gnt !== '0 || rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rst_gnt got=%b/%b exp=0/0", wr_gnt, rd_gnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({arr_wen, arr_waddr, arr_wdata, arr_ren, arr_raddr, rd_vld,
             rd_data, wclk_en, rclk_en, addr_err} !== '0) begin
            errors++;
            $display("FAIL rst_outs got wen=%b ren=%b vld=%b wce=%b rce=%b err=%b exp=0",
                     arr_wen, arr_ren, rd_vld, wclk_en, rclk_en, addr_err);
        end
        rst = 1'b0;
        wr_req = '0;
        rd_req = 1'b0;
        cyc += 2;
        model_reset();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i*16 + 1), rnd_data());
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (obs_gnt !== seq[k]) begin
                errors++;
                $display("FAIL rr_order k=%0d got=%b exp=%b", k, obs_gnt, seq[k]);
            end
            checks++;
            if (arr_wen !== 1'b1 || arr_waddr !== AW'((k % NREQ)*16 + 1)) begin
                errors++;
                $display("FAIL rr_issue k=%0d got=%b/%h exp=1/%h", k, arr_wen,
                         arr_waddr, AW'((k % NREQ)*16 + 1));
            end
        end
        wr_req = '0;
        tick();
    endtask

    task automatic test_ptr();
        wr_req = '0;
        set_req(1, 8'd33, rnd_data());
        tick();
        wr_req = '0;
        set_req(0, 8'd34, rnd_data());
        set_req(1, 8'd35, rnd_data());
        tick();
        checks++;
        if (obs_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_wrap got=%b exp=0001", obs_gnt);
        end
        tick();
        checks++;
        if (obs_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL ptr_next got=%b exp=0010", obs_gnt);
        end
        wr_req = '0;
        tick();
    endtask

    task automatic test_hold();
        logic [4:0] seen;
        for (int k = 0; k < 4; k++) tick();
        set_req(0, 8'd5, 80'hA5);
        tick();
        wr_req = '0;
        seen = '0;
        for (int k = 0; k < 5; k++) begin
            seen[k] = wclk_en;
            tick();
        end
        checks++;
        if (seen !== 5'b00111) begin
            errors++;
            $display("FAIL wclk_hold got=%b exp=00111", seen);
        end
    endtask

    task automatic test_hazard();
        int vcyc;
        logic [DW-1:0] vdata;
        for (int k = 0; k < 4; k++) tick();
        set_req(0, 8'd10, 80'h1234);
        rd_req  = 1'b1;
        rd_addr = 8'd10;
        tick();
        checks++;
        if (obs_rgnt !== BYP) begin
            errors++;
            $display("FAIL haz_gnt_t got=%b exp=%b", obs_rgnt, BYP);
        end
        wr_req = '0;
        rd_req = !BYP;
        vcyc = -1;
        vdata = '0;
        for (int k = 1; k <= 6; k++) begin
            if (rd_vld && vcyc < 0) begin
                vcyc  = k;
                vdata = rd_data;
            end
            tick();
            if (k == 1) begin
                checks++;
                if (obs_rgnt !== !BYP) begin
                    errors++;
                    $display("FAIL haz_gnt_t1 got=%b exp=%b", obs_rgnt, !BYP);
                end
            end
            rd_req = 1'b0;
        end
        checks++;
        if (vcyc != (BYP ? 3 : 4) || vdata !== 80'h1234) begin
            errors++;
            $display("FAIL haz_resp got=T+%0d/%h exp=T+%0d/1234", vcyc, vdata,
                     BYP ? 3 : 4);
        end
    endtask

    task automatic test_illegal();
        int vcyc;
        logic [DW-1:0] vdata;
        set_req(1, 8'd200, rnd_data());
        tick();
        checks++;
        if (obs_gnt === '0) begin
            errors++;
            $display("FAIL ill_gnt got=%b exp=nonzero", obs_gnt);
        end
        wr_req = '0;
        checks++;
        if (arr_wen !== 1'b0 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL ill_wr got wen=%b err=%b exp wen=0 err=1", arr_wen, addr_err);
        end
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL ill_sticky got=%b exp=1", addr_err);
        end
        rd_req  = 1'b1;
        rd_addr = 8'd195;
        tick();
        rd_req = 1'b0;
        vcyc = -1;
        vdata = '1;
        for (int k = 1; k <= 4; k++) begin
            if (rd_vld && vcyc < 0) begin
                vcyc  = k;
                vdata = rd_data;
            end
            tick();
        end
        checks++;
        if (vcyc != 3 || vdata !== '0) begin
            errors++;
            $display("FAIL ill_rd got=T+%0d/%h exp=T+3/0", vcyc, vdata);
        end
    endtask

    task automatic test_random(input int n);
        bit rd_hold;
        int pick;
        rd_hold = 1'b0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!wr_req[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 9) == 0)
                        set_req(i, AW'($urandom_range(188, 195)), rnd_data());
                    else
                        set_req(i, AW'($urandom_range(0, 15)), rnd_data());
                end
            end
            if (!rd_hold) begin
                rd_req = ($urandom_range(0, 1) == 1);
                pick = $urandom_range(0, NREQ - 1);
                if (wr_req[pick] && $urandom_range(0, 1) == 1)
                    rd_addr = wr_addr[pick*AW +: AW];
                else if ($urandom_range(0, 9) == 0)
                    rd_addr = AW'($urandom_range(188, 195));
                else
                    rd_addr = AW'($urandom_range(0, 15));
            end
            tick();
            if (last_gnt >= 0) wr_req[last_gnt] = 1'b0;
            rd_hold = rd_req && !last_rg;
            if (!rd_hold) rd_req = 1'b0;
        end
        wr_req = '0;
        rd_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic test_rst_mid();
        set_req(1, 8'd250, rnd_data());
        rd_req  = 1'b1;
        rd_addr = 8'd3;
        tick();
        checks++;
        if (obs_rgnt !== 1'b1 || obs_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_setup got=%b/%b exp=1/0010", obs_rgnt, obs_gnt);
        end
        wr_req = '0;
        rd_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({arr_wen, arr_waddr, arr_wdata, arr_ren, arr_raddr, rd_vld,
             rd_data, wclk_en, rclk_en, addr_err} !== '0) begin
            errors++;
            $display("FAIL mid_rst got wen=%b ren=%b vld=%b wce=%b rce=%b err=%b exp=0",
                     arr_wen, arr_ren, rd_vld, wclk_en, rclk_en, addr_err);
        end
        rst = 1'b0;
        cyc++;
        model_reset();
        for (int k = 0; k < 4; k++) tick();
        wr_req = 4'b1111;
        tick();
        checks++;
        if (obs_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr got=%b exp=0001", obs_gnt);
        end
        wr_req = '0;
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_round_robin();
        test_ptr();
        test_hold();
        test_hazard();
        test_illegal();
        test_random(300);
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
